alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single-cycle datapath's ALU and its 4-bit ALU control encoding between two requesters (requester 0: main datapath side-path; requester 1: multi-cycle helper such as a multiply/divide sequencer). Captures the winning request's opcode and operands, drives the shared ALU for exactly one cycle, registers the result and returns it with a one-cycle valid pulse. Round-robin arbitration guarantees neither requester starves, and illegal control codes are rejected without reaching the ALU.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- req0 / req1  in  1  request from requester 0 / 1; held high until its gnt
- op0 / op1  in  4  ALU control code for the request
- a0, b0 / a1, b1  in  WIDTH  operands
- gnt0 / gnt1  out  1  one-cycle pulse: request captured, requester may change inputs
- alu_ctrl  out  4  control to shared ALU
- alu_a, alu_b  out  WIDTH  operands to shared ALU
- alu_result  in  WIDTH  combinational ALU result
- alu_zero  in  1  ALU zero flag
- rsp_valid0 / rsp_valid1  out  1  one-cycle response pulse to owner
- rsp_data  out  WIDTH  registered result (shared by both requesters)
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  qualifies rsp_valid: request carried an illegal code

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- Arbitration only in IDLE and RESP. Candidates: reqN high. One candidate wins outright; both high: winner is the requester not granted last. Pointer reset value: last = 1 (requester 0 wins first tie).
- On win: capture op, a, b of winner into internal regs; record owner; update pointer; next state EXEC. No candidate: IDLE→IDLE, RESP→IDLE.
- Legal codes: 0000 and, 0001 or, 0010 add, 0100 shift, 0110 xor, 1010 sub, 1011 slt, 1101 lui-type. Any other code is flagged illegal at capture.
- EXEC: gntN of owner high. If legal, alu_ctrl/alu_a/alu_b = captured values; at end of cycle register alu_result→rsp_data, alu_zero→rsp_zero, rsp_err=0. If illegal, ALU outputs stay at idle values; register rsp_data=0, rsp_zero=0, rsp_err=1. Next state RESP.
- RESP: rsp_validN of owner high, rsp_data/rsp_zero/rsp_err valid; arbitration runs as above.
- Outside legal EXEC: alu_ctrl=4'b0010, alu_a=0, alu_b=0.
- rsp_data/rsp_zero/rsp_err hold their value until the next EXEC completes.
- Requester that keeps req high through RESP is sampled again there (back-to-back op); requester must deassert req in its gnt cycle to avoid a repeat.

## Timing
- Reset values: gnt0/1=0, rsp_valid0/1=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_ctrl=4'b0010, alu_a=alu_b=0, pointer last=1, state IDLE.
- Req seen in cycle t (IDLE) → gnt in t+1 → rsp_valid in t+2. Latency 2 cycles; peak throughput one op per 2 cycles.
- gnt and rsp_valid are exactly one cycle wide and never asserted to both requesters in the same cycle.
- reqN changes during EXEC are ignored; captured values are used.
- Reset mid-EXEC or mid-RESP: outputs return to reset values immediately; in-flight op discarded with no rsp_valid; still-high requests re-arbitrated from IDLE after release (requester 0 first on tie).

## Test plan
- Single op: req0, op0=0010, a0=5, b0=7 in IDLE → gnt0 next cycle with alu_ctrl=0010, alu_a=5, alu_b=7; rsp_valid0 following cycle with rsp_data=12, rsp_zero=0, rsp_err=0.
- Tie after reset: req0 and req1 both held (op 1010, 9−9; op 0001, 3|4) → order gnt0, gnt1, gnt0 alternating; responses 0 with rsp_zero=1, and 7.
- Back-to-back: req1 held high, op1=1011, a1=1, b1=2 → gnt1 every 2 cycles, rsp_valid1 every 2 cycles with rsp_data=1; no idle cycle between.
- Illegal code: req0, op0=1111 → gnt0, ALU outputs stay 0010/0/0, then rsp_valid0 with rsp_err=1, rsp_data=0.
- Reset mid-op: assert reset during EXEC of req1 → gnt1/ALU outputs drop same cycle, no rsp_valid1; release with req0 and req1 high → gnt0 first.
- Operand change after gnt: a0 changes in EXEC cycle → rsp_data reflects originally captured a0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Lets two requesters share one single-cycle ALU. Requester 0 is the main
// datapath side-path and requester 1 is a multi-cycle helper (for example a
// multiply/divide sequencer). A round-robin arbiter picks one request and
// captures its opcode and operands. The captured operation drives the shared
// ALU for exactly one cycle. The registered result is then returned to the
// owner with a one-cycle valid pulse. Control codes the ALU does not implement
// never reach the ALU. They come back as an error response instead.
//
// Sequence: IDLE -> EXEC (grant pulse, ALU driven) -> RESP (response pulse,
// arbitration runs again) -> EXEC or IDLE. A requester that holds its request
// gets one operation every two cycles.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-high; clears all state
//   req0 / req1          request, held high until the matching grant
//   op0 / op1            4-bit ALU control code of the request
//   a0, b0 / a1, b1      operands of the request
//   gnt0 / gnt1          one-cycle pulse: request captured, inputs may change
//   alu_ctrl             control code to the shared ALU
//   alu_a, alu_b         operands to the shared ALU
//   alu_result           combinational result from the shared ALU
//   alu_zero             zero flag from the shared ALU
//   rsp_valid0 / 1       one-cycle response pulse to the owner
//   rsp_data             registered result, shared by both requesters
//   rsp_zero             registered zero flag
//   rsp_err              qualifies rsp_valid: request carried an illegal code

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [3:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [3:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  // When no operation is executing, the ALU sees an add of zero and zero.
  localparam logic [3:0] IDLE_CTRL = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Round-robin pointer: the requester that was granted last.
  logic last;
  // Owner of the operation in flight.
  logic owner;
  // The captured code was illegal.
  logic illegal;

  // Combinational arbitration result. It is only acted on in IDLE and RESP.
  logic             win_valid;
  logic             win_sel;
  logic [3:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             win_legal;

  // Control codes implemented by the shared ALU.
  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0110, 4'b1010, 4'b1011, 4'b1101: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  // A single request wins outright. On a tie, the requester that was not
  // granted last wins, so a continuously requesting peer cannot starve the
  // other requester.
  always_comb begin
    win_valid = req0 | req1;
    win_sel   = 1'b0;
    if (req0 && req1) begin
      win_sel = ~last;
    end else if (req1) begin
      win_sel = 1'b1;
    end
    win_op    = win_sel ? op1 : op0;
    win_a     = win_sel ? a1  : a0;
    win_b     = win_sel ? b1  : b0;
    win_legal = is_legal(win_op);
  end

  // The control FSM and all outputs live in this block.
  // The outputs for EXEC are loaded on the edge that enters EXEC. Because
  // they are registered, the grant, the ALU drive and the later response
  // each appear for exactly one cycle without decode glitches.
  // An illegal code loads the idle ALU values, so the shared ALU never
  // sees that code.
  // rsp_data, rsp_zero and rsp_err change only when an EXEC cycle
  // completes. They hold their value through RESP and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      illegal    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      alu_ctrl   <= IDLE_CTRL;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          rsp_valid0 <= 1'b0;
          rsp_valid1 <= 1'b0;
          if (win_valid) begin
            state   <= EXEC;
            owner   <= win_sel;
            last    <= win_sel;
            illegal <= ~win_legal;
            gnt0    <= ~win_sel;
            gnt1    <= win_sel;
            if (win_legal) begin
              alu_ctrl <= win_op;
              alu_a    <= win_a;
              alu_b    <= win_b;
            end else begin
              alu_ctrl <= IDLE_CTRL;
              alu_a    <= '0;
              alu_b    <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end

        EXEC: begin
          state      <= RESP;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          alu_ctrl   <= IDLE_CTRL;
          alu_a      <= '0;
          alu_b      <= '0;
          rsp_valid0 <= ~owner;
          rsp_valid1 <= owner;
          if (illegal) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          alu_ctrl   <= IDLE_CTRL;
          alu_a      <= '0;
          alu_b      <= '0;
          rsp_valid0 <= 1'b0;
          rsp_valid1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. The bench provides a reference
// single-cycle ALU that the DUT drives. Single operations come from a table
// of hand-computed vectors. Hand-written sequences cover the reset state,
// tie arbitration, back-to-back operations, operand changes after the grant,
// and reset in the middle of an operation.
//
// Ports: none (top-level bench).

module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [3:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid0, rsp_valid1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  int checks;
  int errors;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .op0        (op0),
    .a0         (a0),
    .b0         (b0),
    .req1       (req1),
    .op1        (op1),
    .a1         (a1),
    .b1         (b1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid0 (rsp_valid0),
    .rsp_valid1 (rsp_valid1),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shared ALU: the lui-type code places b in the upper half.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_a << alu_b[4:0];
      4'b0110: alu_result = alu_a ^ alu_b;
      4'b1010: alu_result = alu_a - alu_b;
      4'b1011: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1101: alu_result = {alu_b[15:0], 16'd0};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct packed {
    logic             who;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic who, input logic req,
                               input logic [3:0] op,
                               input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    if (who) begin
      req1 = req; op1 = op; a1 = a; b1 = b;
    end else begin
      req0 = req; op0 = op; a0 = a; b0 = b;
    end
  endtask

  task automatic checkOutput(input string name,
                             input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Bounds the whole run so that the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] prev_data;
    logic             exp_gnt0, exp_gnt1;

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;

    vecs[0] = '{who:1'b0, op:4'b0010, a:32'd5,        b:32'd7,        data:32'd12,        zero:1'b0, err:1'b0};
    vecs[1] = '{who:1'b0, op:4'b1010, a:32'd9,        b:32'd9,        data:32'd0,         zero:1'b1, err:1'b0};
    vecs[2] = '{who:1'b1, op:4'b0001, a:32'd3,        b:32'd4,        data:32'd7,         zero:1'b0, err:1'b0};
    vecs[3] = '{who:1'b0, op:4'b0000, a:32'h0000F0F0, b:32'h00000FF0, data:32'h000000F0,  zero:1'b0, err:1'b0};
    vecs[4] = '{who:1'b1, op:4'b0100, a:32'd1,        b:32'd4,        data:32'd16,        zero:1'b0, err:1'b0};
    vecs[5] = '{who:1'b0, op:4'b0110, a:32'h000000FF, b:32'h0000000F, data:32'h000000F0,  zero:1'b0, err:1'b0};
    vecs[6] = '{who:1'b1, op:4'b1011, a:32'hFFFFFFFF, b:32'd1,        data:32'd1,         zero:1'b0, err:1'b0};
    vecs[7] = '{who:1'b0, op:4'b1101, a:32'd0,        b:32'h00001234, data:32'h12340000,  zero:1'b0, err:1'b0};
    vecs[8] = '{who:1'b0, op:4'b1111, a:32'd8,        b:32'd8,        data:32'd0,         zero:1'b0, err:1'b1};
    vecs[9] = '{who:1'b1, op:4'b0011, a:32'd2,        b:32'd2,        data:32'd0,         zero:1'b0, err:1'b1};

    // Reset state.
    #1 reset = 1'b1;
    #2;
    checkOutput("reset gnt0",       {31'd0, gnt0},       32'd0);
    checkOutput("reset gnt1",       {31'd0, gnt1},       32'd0);
    checkOutput("reset rsp_valid0", {31'd0, rsp_valid0}, 32'd0);
    checkOutput("reset rsp_valid1", {31'd0, rsp_valid1}, 32'd0);
    checkOutput("reset rsp_data",   rsp_data,            32'd0);
    checkOutput("reset rsp_zero",   {31'd0, rsp_zero},   32'd0);
    checkOutput("reset rsp_err",    {31'd0, rsp_err},    32'd0);
    checkOutput("reset alu_ctrl",   {28'd0, alu_ctrl},   32'd2);
    checkOutput("reset alu_a",      alu_a,               32'd0);
    checkOutput("reset alu_b",      alu_b,               32'd0);
    step();
    step();
    reset = 1'b0;

    // Tie after reset: requester 0 wins first, then the grants alternate.
    $display("[TB] tie arbitration");
    applyStimulus(1'b0, 1'b1, 4'b1010, 32'd9, 32'd9);
    applyStimulus(1'b1, 1'b1, 4'b0001, 32'd3, 32'd4);
    step();
    checkOutput("tie gnt0 first", {31'd0, gnt0}, 32'd1);
    checkOutput("tie gnt1 first", {31'd0, gnt1}, 32'd0);
    step();
    checkOutput("tie rsp_valid0 a", {31'd0, rsp_valid0}, 32'd1);
    checkOutput("tie rsp_data a",   rsp_data,            32'd0);
    checkOutput("tie rsp_zero a",   {31'd0, rsp_zero},   32'd1);
    step();
    checkOutput("tie gnt1 second", {31'd0, gnt1}, 32'd1);
    checkOutput("tie gnt0 second", {31'd0, gnt0}, 32'd0);
    step();
    checkOutput("tie rsp_valid1",   {31'd0, rsp_valid1}, 32'd1);
    checkOutput("tie rsp_valid0 b", {31'd0, rsp_valid0}, 32'd0);
    checkOutput("tie rsp_data b",   rsp_data,            32'd7);
    checkOutput("tie rsp_zero b",   {31'd0, rsp_zero},   32'd0);
    step();
    checkOutput("tie gnt0 third", {31'd0, gnt0}, 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    checkOutput("tie rsp_data c", rsp_data, 32'd0);
    step();

    // Back-to-back: a held request is served every two cycles.
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b1, 4'b1011, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("b2b gnt1",     {31'd0, gnt1},     32'd1);
      checkOutput("b2b alu_ctrl", {28'd0, alu_ctrl}, 32'hB);
      if (i == 2) applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
      step();
      checkOutput("b2b rsp_valid1", {31'd0, rsp_valid1}, 32'd1);
      checkOutput("b2b gnt1 low",   {31'd0, gnt1},       32'd0);
      checkOutput("b2b rsp_data",   rsp_data,            32'd1);
    end
    step();
    checkOutput("b2b idle gnt1", {31'd0, gnt1}, 32'd0);

    // Table of single operations, each issued from IDLE.
    $display("[TB] vector table");
    prev_data = rsp_data;
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].who, 1'b1, vecs[v].op, vecs[v].a, vecs[v].b);
      step();
      exp_gnt0 = ~vecs[v].who;
      exp_gnt1 = vecs[v].who;
      checkOutput("vec gnt0", {31'd0, gnt0}, {31'd0, exp_gnt0});
      checkOutput("vec gnt1", {31'd0, gnt1}, {31'd0, exp_gnt1});
      checkOutput("vec alu_ctrl", {28'd0, alu_ctrl},
                  vecs[v].err ? 32'd2 : {28'd0, vecs[v].op});
      checkOutput("vec alu_a", alu_a, vecs[v].err ? 32'd0 : vecs[v].a);
      checkOutput("vec alu_b", alu_b, vecs[v].err ? 32'd0 : vecs[v].b);
      checkOutput("vec rsp_data hold", rsp_data, prev_data);
      applyStimulus(vecs[v].who, 1'b0, 4'b0000, 32'd0, 32'd0);
      step();
      checkOutput("vec rsp_valid0", {31'd0, rsp_valid0}, {31'd0, exp_gnt0});
      checkOutput("vec rsp_valid1", {31'd0, rsp_valid1}, {31'd0, exp_gnt1});
      checkOutput("vec rsp_data",   rsp_data,            vecs[v].data);
      checkOutput("vec rsp_zero",   {31'd0, rsp_zero},   {31'd0, vecs[v].zero});
      checkOutput("vec rsp_err",    {31'd0, rsp_err},    {31'd0, vecs[v].err});
      checkOutput("vec gnt off",    {30'd0, gnt0, gnt1}, 32'd0);
      step();
      checkOutput("vec valid off", {30'd0, rsp_valid0, rsp_valid1}, 32'd0);
      prev_data = vecs[v].data;
    end

    // Operands that change after the grant are ignored.
    $display("[TB] operand change after grant");
    applyStimulus(1'b0, 1'b1, 4'b0010, 32'd5, 32'd7);
    step();
    checkOutput("chg gnt0", {31'd0, gnt0}, 32'd1);
    applyStimulus(1'b0, 1'b0, 4'b0110, 32'd100, 32'd1);
    step();
    checkOutput("chg rsp_valid0", {31'd0, rsp_valid0}, 32'd1);
    checkOutput("chg rsp_data",   rsp_data,            32'd12);
    step();

    // Reset during EXEC discards the operation. After release, the tie
    // goes to requester 0.
    $display("[TB] reset mid-op");
    applyStimulus(1'b1, 1'b1, 4'b0010, 32'd1, 32'd1);
    step();
    checkOutput("rst gnt1 before", {31'd0, gnt1}, 32'd1);
    checkOutput("rst alu_a before", alu_a,        32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b0110, 32'd6, 32'd3);
    #1;
    checkOutput("rst gnt1 drop",     {31'd0, gnt1},     32'd0);
    checkOutput("rst alu_ctrl drop", {28'd0, alu_ctrl}, 32'd2);
    checkOutput("rst alu_a drop",    alu_a,             32'd0);
    step();
    checkOutput("rst no rsp_valid1", {31'd0, rsp_valid1}, 32'd0);
    checkOutput("rst rsp_data",      rsp_data,            32'd0);
    reset = 1'b0;
    step();
    checkOutput("rst gnt0 first", {31'd0, gnt0}, 32'd1);
    checkOutput("rst gnt1 wait",  {31'd0, gnt1}, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    checkOutput("rst rsp_valid0", {31'd0, rsp_valid0}, 32'd1);
    checkOutput("rst rsp_data0",  rsp_data,            32'd5);
    step();
    checkOutput("rst gnt1 after", {31'd0, gnt1}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    checkOutput("rst rsp_valid1", {31'd0, rsp_valid1}, 32'd1);
    checkOutput("rst rsp_data1",  rsp_data,            32'd2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
